prominence_frame_scheduler: RTL and testbench
=============================================

Name: prominence_frame_scheduler

Overview:
Sequences spectrum frames into the prominence_analysis core. Sits between the AXI-Stream spectrum source and the analysis core's stream slave. Passes whole frames only (first beat marked by tuser, last by tlast), in single-shot or continuous mode with optional frame decimation. Discards unselected beats, checks frame length and reports completion and errors to the control domain.

Parameters:
DW, 16, stream data width
FRAME_LEN, 1024, expected beats per frame (tuser beat through tlast beat)
DECW, 8, width of the decimation count
CNTW, 16, width of the completed-frame counter

Ports:
clk  in  1  clock
reset_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle arm request
stop  in  1  one-cycle stop request
mode_cont  in  1  0 = single-shot, 1 = continuous
decim  in  DECW  frames to skip between analysed frames in continuous mode
s_tdata  in  DW  upstream data
s_tuser  in  1  upstream start-of-frame
s_tlast  in  1  upstream end-of-frame
s_tvalid  in  1  upstream valid
s_tready  out  1  upstream ready
m_tdata  out  DW  to core tdata_s
m_tuser  out  1  to core tuser_s
m_tlast  out  1  to core tlast_s
m_tvalid  out  1  to core tvalid_s
m_tready  in  1  from core tready_s
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse on the accepted m_tlast beat
frame_cnt  out  CNTW  completed frames, wraps modulo 2^CNTW
len_err  out  1  sticky; cleared by start

Behaviour:
- States: IDLE, WAIT_SOF, PASS, SKIP. Async reset: state IDLE, frame_cnt 0, len_err 0, frame_done 0, skip_cnt 0, beat_cnt 0.
- While reset_n is low: s_tready 0, m_tvalid 0. A registered out-of-reset flag gates both.
- Datapath is combinational and has zero latency. m_tdata, m_tuser and m_tlast always mirror s_*.
- IDLE, SKIP, and WAIT_SOF with s_tuser=0: s_tready=1, m_tvalid=0 (drain/discard).
- PASS, and WAIT_SOF with s_tuser=1: m_tvalid=s_tvalid, s_tready=m_tready.
- IDLE -> WAIT_SOF on start. start also clears len_err.
- WAIT_SOF -> PASS on an accepted tuser beat; beat_cnt is set to 1.
  - If that beat also has tlast, the frame completes in the same cycle (see completion rule).
- PASS: beat_cnt increments on each handshake.
  - Accepted tuser beat before tlast: set len_err, pass the beat, reload beat_cnt to 1.
  - Accepted tlast beat: frame_done=1 and frame_cnt+1 on the next edge. len_err is set if final beat_cnt != FRAME_LEN.
- Completion transitions, in priority order:
  - stop pending or mode_cont=0 -> IDLE.
  - decim=0 -> WAIT_SOF.
  - otherwise -> SKIP with skip_cnt=decim.
- SKIP: each accepted s_tlast beat decrements skip_cnt. The beat that reaches 0 moves to WAIT_SOF.
- stop:
  - In WAIT_SOF or SKIP: -> IDLE on the next edge.
  - In PASS: latched as pending; the current frame completes, then -> IDLE. Pending stop is cleared on entering IDLE.
  - start and stop in the same cycle: stop wins. start outside IDLE is ignored.
- mode_cont and decim are sampled only at frame completion.
- An async reset mid-frame aborts immediately. The core sees a truncated frame, which the core handles.

Decomposition:
- prom_sched_pkg holds:
  - state encoding (IDLE=0, WAIT_SOF=1, PASS=2, SKIP=3);
  - MODE_SINGLE / MODE_CONT constants;
  - the beat-counter width function clog2(FRAME_LEN)+1.
- One sub-module, axis_frame_gate: the pass/discard mux, the ready/valid steering and the beat counter with length compare. The FSM and counters stay in the top.

Test Plan:
1. Single-shot: start mid-frame with FRAME_LEN=1024 and a free-running source -> beats before the next tuser are discarded. Exactly 1024 beats reach m_*, frame_done pulses once, frame_cnt=1, busy drops the cycle after the tlast handshake.
2. Continuous with decim=2 over 9 source frames -> frames 1, 4 and 7 are passed. frame_cnt=3, no m_tvalid during skipped frames.
3. Backpressure: m_tready toggles randomly at 50% in PASS -> s_tready equals m_tready, no beat is lost or duplicated, and the data checksum matches the source frame.
4. Length error: source sends tlast after 1000 beats -> len_err=1 and frame_done still pulses. A second source sends tuser at beat 512 -> len_err=1 and beat_cnt restarts. A following start clears len_err.
5. Stop: stop asserted at beat 300 of PASS in continuous mode -> the frame runs to beat 1024, then IDLE. Stop in SKIP -> IDLE on the next cycle. start and stop in the same cycle in IDLE -> stays IDLE.
6. Reset: reset_n low at beat 600 -> s_tready=0, m_tvalid=0, frame_cnt=0 and state IDLE immediately. After release, s_tready=1 and beats are discarded until start.

Source files
------------

// File: rtl/prom_sched_pkg.sv
// Shared types and helpers for the prominence frame scheduler.
//   sched_state_t : scheduler FSM encoding
//   MODE_SINGLE / MODE_CONT : values of the mode_cont control input
//   beat_cnt_w()  : width of a beat counter able to hold FRAME_LEN
package prom_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_PASS     = 2'd2,
        ST_SKIP     = 2'd3
    } sched_state_t;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

    // One extra bit so the counter can hold FRAME_LEN itself.
    function automatic int unsigned beat_cnt_w(input int unsigned frame_len);
        return $clog2(frame_len) + 1;
    endfunction

endpackage

// File: rtl/axis_frame_gate.sv
// Pass/discard gate between the spectrum source and the analysis core.
// Steers ready/valid from the scheduler state, mirrors the payload with zero
// latency and counts forwarded beats to judge frame length.
//   clk, reset_n      : clock, async active-low reset
//   out_en            : registered out-of-reset flag; gates both handshakes
//   state             : scheduler state
//   s_t*, s_tready    : upstream AXI-Stream slave side
//   m_t*, m_tready    : downstream AXI-Stream master side
//   fwd_acc_c         : a beat was handed to the core this cycle
//   src_acc_c         : a beat was taken from the source this cycle
//   len_err_c         : the forwarded beat reveals a framing/length error
module axis_frame_gate
    import prom_sched_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned FRAME_LEN = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          out_en,
    input  sched_state_t  state,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tuser,
    input  logic          s_tlast,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tuser,
    output logic          m_tlast,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic          fwd_acc_c,
    output logic          src_acc_c,
    output logic          len_err_c
);

    localparam int unsigned BW = beat_cnt_w(FRAME_LEN);

    logic          fwd;
    logic [BW-1:0] beat_cnt;
    logic [BW-1:0] beat_nxt;

    // Forward in PASS, or in WAIT_SOF only for the start-of-frame beat.
    assign fwd = (state == ST_PASS) || ((state == ST_WAIT_SOF) && s_tuser);

    assign m_tdata  = s_tdata;
    assign m_tuser  = s_tuser;
    assign m_tlast  = s_tlast;
    assign m_tvalid = out_en && fwd && s_tvalid;
    assign s_tready = out_en && (fwd ? m_tready : 1'b1);

    assign src_acc_c = s_tvalid && s_tready;
    assign fwd_acc_c = m_tvalid && m_tready;

    // Beat count including the current beat; a tuser beat restarts at 1.
    // Saturates so an overlong frame can never alias back onto FRAME_LEN.
    always_comb begin
        beat_nxt = beat_cnt;
        if (fwd_acc_c) begin
            if (s_tuser) begin
                beat_nxt = BW'(1);
            end else if (beat_cnt != '1) begin
                beat_nxt = beat_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
        end else begin
            beat_cnt <= beat_nxt;
        end
    end

    // Error on a tuser inside a running frame, or a tlast at the wrong count.
    assign len_err_c = fwd_acc_c &&
                       ((s_tuser && (state == ST_PASS)) ||
                        (s_tlast && (beat_nxt != BW'(FRAME_LEN))));

endmodule

// File: rtl/prominence_frame_scheduler.sv
// Sequences whole spectrum frames into the prominence_analysis core in
// single-shot or continuous mode with optional decimation.
//   clk, reset_n          : clock, async active-low reset
//   start, stop           : one-cycle control requests (stop wins)
//   mode_cont, decim      : run mode and frames skipped between analysed frames
//   s_t*                  : AXI-Stream from the spectrum source
//   m_t*                  : AXI-Stream to the analysis core
//   busy                  : scheduler not idle
//   frame_done            : pulse after the forwarded tlast beat
//   frame_cnt             : completed frames, wrapping
//   len_err               : sticky framing/length error, cleared by start
module prominence_frame_scheduler
    import prom_sched_pkg::*;
#(
    parameter int unsigned DW        = 16,
    parameter int unsigned FRAME_LEN = 1024,
    parameter int unsigned DECW      = 8,
    parameter int unsigned CNTW      = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic            stop,
    input  logic            mode_cont,
    input  logic [DECW-1:0] decim,
    input  logic [DW-1:0]   s_tdata,
    input  logic            s_tuser,
    input  logic            s_tlast,
    input  logic            s_tvalid,
    output logic            s_tready,
    output logic [DW-1:0]   m_tdata,
    output logic            m_tuser,
    output logic            m_tlast,
    output logic            m_tvalid,
    input  logic            m_tready,
    output logic            busy,
    output logic            frame_done,
    output logic [CNTW-1:0] frame_cnt,
    output logic            len_err
);

    sched_state_t    state;
    sched_state_t    state_d;
    sched_state_t    done_state;
    logic            out_en;
    logic            stop_pend;
    logic            stop_pend_d;
    logic [DECW-1:0] skip_cnt;
    logic [DECW-1:0] skip_cnt_d;
    logic [CNTW-1:0] frame_cnt_d;
    logic            len_err_d;
    logic            frame_done_d;
    logic            fwd_acc;
    logic            src_acc;
    logic            gate_len_err;
    logic            eof_acc;

    axis_frame_gate #(
        .DW        (DW),
        .FRAME_LEN (FRAME_LEN)
    ) u_gate (
        .clk       (clk),
        .reset_n   (reset_n),
        .out_en    (out_en),
        .state     (state),
        .s_tdata   (s_tdata),
        .s_tuser   (s_tuser),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (s_tready),
        .m_tdata   (m_tdata),
        .m_tuser   (m_tuser),
        .m_tlast   (m_tlast),
        .m_tvalid  (m_tvalid),
        .m_tready  (m_tready),
        .fwd_acc_c (fwd_acc),
        .src_acc_c (src_acc),
        .len_err_c (gate_len_err)
    );

    assign eof_acc = fwd_acc && s_tlast;
    assign busy    = (state != ST_IDLE);

    // Holds both handshakes low until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_en <= 1'b0;
        end else begin
            out_en <= 1'b1;
        end
    end

    // Where a completed frame leads; mode and decim are only looked at here.
    always_comb begin
        done_state = ST_SKIP;
        if (stop_pend || stop || (mode_cont == MODE_SINGLE)) begin
            done_state = ST_IDLE;
        end else if (decim == '0) begin
            done_state = ST_WAIT_SOF;
        end
    end

    // State register and counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            stop_pend  <= 1'b0;
            skip_cnt   <= '0;
            frame_cnt  <= '0;
            len_err    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_d;
            stop_pend  <= stop_pend_d;
            skip_cnt   <= skip_cnt_d;
            frame_cnt  <= frame_cnt_d;
            len_err    <= len_err_d;
            frame_done <= frame_done_d;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d      = state;
        stop_pend_d  = stop_pend;
        skip_cnt_d   = skip_cnt;
        frame_cnt_d  = frame_cnt;
        len_err_d    = len_err;
        frame_done_d = 1'b0;

        if (eof_acc) begin
            frame_done_d = 1'b1;
            frame_cnt_d  = frame_cnt + CNTW'(1);
        end
        if (gate_len_err) begin
            len_err_d = 1'b1;
        end

        unique case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_d   = ST_WAIT_SOF;
                    len_err_d = 1'b0;
                end
            end
            ST_WAIT_SOF: begin
                if (fwd_acc) begin
                    // Once the tuser beat reached the core the frame is
                    // running, so a coincident stop lets it finish.
                    state_d = ST_PASS;
                    if (stop) begin
                        stop_pend_d = 1'b1;
                    end
                    if (s_tlast) begin
                        state_d    = done_state;
                        skip_cnt_d = decim;
                    end
                end else if (stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_PASS: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end
                if (eof_acc) begin
                    state_d    = done_state;
                    skip_cnt_d = decim;
                end
            end
            ST_SKIP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (src_acc && s_tlast) begin
                    skip_cnt_d = skip_cnt - DECW'(1);
                    if (skip_cnt <= DECW'(1)) begin
                        state_d = ST_WAIT_SOF;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_d == ST_IDLE) begin
            stop_pend_d = 1'b0;
        end
    end

endmodule

// File: tb/tb_prominence_frame_scheduler.sv
`timescale 1ns/1ps
module tb_prominence_frame_scheduler;

    localparam int unsigned DW        = 16;
    localparam int unsigned FRAME_LEN = 1024;
    localparam int unsigned DECW      = 8;
    localparam int unsigned CNTW      = 16;

    logic            clk = 1'b0;
    logic            reset_n;
    logic            start;
    logic            stop;
    logic            mode_cont;
    logic [DECW-1:0] decim;
    logic [DW-1:0]   s_tdata;
    logic            s_tuser;
    logic            s_tlast;
    logic            s_tvalid;
    logic            s_tready;
    logic [DW-1:0]   m_tdata;
    logic            m_tuser;
    logic            m_tlast;
    logic            m_tvalid;
    logic            m_tready;
    logic            busy;
    logic            frame_done;
    logic [CNTW-1:0] frame_cnt;
    logic            len_err;

    prominence_frame_scheduler #(
        .DW(DW), .FRAME_LEN(FRAME_LEN), .DECW(DECW), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .mode_cont(mode_cont), .decim(decim),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tlast(s_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tlast(m_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready),
        .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt),
        .len_err(len_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          u;
        logic          l;
    } beat_t;

    int      tests = 0;
    int      fails = 0;
    int      src_frame = 0;
    int      src_beat = 0;
    int      short_frame = -1;
    int      glitch_frame = -1;
    int      glitch_at = 512;
    bit      pass_frame [0:255];
    bit      bp_en = 1'b0;
    beat_t   exp_q [$];
    int      m_beats = 0;
    int      done_cnt = 0;
    bit      fd_seen = 1'b0;
    logic    snap_busy;
    logic    snap_len_err;
    logic [CNTW-1:0] snap_cnt;
    logic    last_hs_busy;
    int      sum_exp = 0;
    int      sum_obs = 0;
    bit      glitch_pending = 1'b0;
    int      glitch_checked = 0;
    bit      src_hs;

    function automatic int src_len(input int f);
        return (f == short_frame) ? 1000 : 1024;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive source at edge+1, monitor at negedge, advance source.
    task automatic cyc();
        beat_t b;
        s_tvalid = 1'b1;
        s_tdata  = DW'(src_frame * 1024 + src_beat);
        s_tuser  = (src_beat == 0) || ((src_frame == glitch_frame) && (src_beat == glitch_at));
        s_tlast  = (src_beat == src_len(src_frame) - 1);
        m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        src_hs = s_tvalid && s_tready;
        if (glitch_pending) begin
            chk("beat_cnt_restart", 32'(dut.u_gate.beat_cnt), 32'd1);
            glitch_pending = 1'b0;
            glitch_checked++;
        end
        if (src_hs && pass_frame[src_frame]) begin
            b.d = s_tdata; b.u = s_tuser; b.l = s_tlast;
            exp_q.push_back(b);
            sum_exp += int'(s_tdata);
        end
        if (m_tvalid) chk("ready_mirror", 32'(s_tready), 32'(m_tready));
        if (m_tvalid && m_tready) begin
            m_beats++;
            last_hs_busy = busy;
            sum_obs += int'(m_tdata);
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                b = exp_q.pop_front();
                chk("beat_data", 32'({m_tdata, m_tuser, m_tlast}), 32'({b.d, b.u, b.l}));
            end
            if ((src_frame == glitch_frame) && (src_beat == glitch_at)) glitch_pending = 1'b1;
        end
        if (frame_done) begin
            fd_seen = 1'b1;
            done_cnt++;
            snap_busy = busy;
            snap_cnt = frame_cnt;
            snap_len_err = len_err;
        end
        @(posedge clk);
        #1;
        if (src_hs) begin
            if (src_beat == src_len(src_frame) - 1) begin
                src_frame++;
                src_beat = 0;
            end else begin
                src_beat++;
            end
        end
    endtask

    task automatic run_to(input int f, input int bt, input int budget);
        int n = 0;
        while (!((src_frame == f) && (src_beat == bt)) && (n < budget)) begin
            cyc();
            n++;
        end
        chk("run_to_reached", 32'(n < budget), 32'd1);
    endtask

    task automatic run_to_beat(input int bt);
        run_to((src_beat < bt) ? src_frame : src_frame + 1, bt, 3000);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        fd_seen = 1'b0;
        while (!fd_seen && (n < budget)) begin
            cyc();
            n++;
        end
        chk("frame_done_seen", 32'(fd_seen), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    int f;
    int mb0;
    int dc0;

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; mode_cont = 1'b0; decim = '0;
        s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 256; i++) pass_frame[i] = 1'b0;

        // Reset state
        repeat (3) cyc();
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("rst_len_err", 32'(len_err), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        reset_n = 1'b1;
        repeat (2) cyc();
        chk("idle_s_tready", 32'(s_tready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);

        // 1: single-shot, armed mid-frame
        run_to_beat(100);
        f = src_frame; pass_frame[f + 1] = 1'b1; mode_cont = 1'b0;
        mb0 = m_beats; dc0 = done_cnt;
        pulse_start();
        chk("t1_busy_armed", 32'(busy), 32'd1);
        wait_done(3000);
        chk("t1_beats", 32'(m_beats - mb0), 32'd1024);
        chk("t1_busy_at_last", 32'(last_hs_busy), 32'd1);
        chk("t1_busy_after", 32'(snap_busy), 32'd0);
        chk("t1_frame_cnt", 32'(snap_cnt), 32'd1);
        repeat (2) cyc();
        chk("t1_done_once", 32'(done_cnt - dc0), 32'd1);
        chk("t1_len_err", 32'(len_err), 32'd0);

        // 2: continuous, decim=2, then stop while skipping
        run_to_beat(100);
        f = src_frame;
        pass_frame[f + 1] = 1'b1; pass_frame[f + 4] = 1'b1; pass_frame[f + 7] = 1'b1;
        mode_cont = 1'b1; decim = DECW'(2); mb0 = m_beats;
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            wait_done(4000);
            chk("t2_frame_cnt", 32'(snap_cnt), 32'(2 + k));
        end
        chk("t2_beats", 32'(m_beats - mb0), 32'd3072);
        chk("t2_busy_skip", 32'(busy), 32'd1);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t5_stop_skip_idle", 32'(busy), 32'd0);

        // 3: random backpressure
        mode_cont = 1'b0; bp_en = 1'b1;
        run_to_beat(100);
        f = src_frame; pass_frame[f + 1] = 1'b1;
        sum_exp = 0; sum_obs = 0; mb0 = m_beats;
        pulse_start();
        wait_done(5000);
        bp_en = 1'b0;
        chk("t3_beats", 32'(m_beats - mb0), 32'd1024);
        chk("t3_checksum", 32'(sum_obs), 32'(sum_exp));
        chk("t3_frame_cnt", 32'(snap_cnt), 32'd5);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4a: short frame
        run_to_beat(100);
        f = src_frame; short_frame = f + 1; pass_frame[f + 1] = 1'b1; mb0 = m_beats;
        pulse_start();
        wait_done(3000);
        chk("t4_short_beats", 32'(m_beats - mb0), 32'd1000);
        chk("t4_short_len_err", 32'(snap_len_err), 32'd1);
        chk("t4_short_frame_cnt", 32'(snap_cnt), 32'd6);

        // 4b: tuser in the middle of a frame
        run_to_beat(100);
        f = src_frame; glitch_frame = f + 1; pass_frame[f + 1] = 1'b1;
        pulse_start();
        chk("t4_start_clears", 32'(len_err), 32'd0);
        wait_done(3000);
        chk("t4_glitch_len_err", 32'(snap_len_err), 32'd1);
        chk("t4_glitch_checked", 32'(glitch_checked), 32'd1);
        chk("t4_glitch_frame_cnt", 32'(snap_cnt), 32'd7);

        // 5a: stop during PASS in continuous mode
        run_to_beat(100);
        f = src_frame; pass_frame[f + 1] = 1'b1;
        mode_cont = 1'b1; decim = '0; mb0 = m_beats;
        pulse_start();
        chk("t5_start_clears", 32'(len_err), 32'd0);
        run_to(f + 1, 300, 3000);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("t5_busy_pass", 32'(busy), 32'd1);
        wait_done(2000);
        chk("t5_beats", 32'(m_beats - mb0), 32'd1024);
        chk("t5_idle_after", 32'(snap_busy), 32'd0);
        chk("t5_frame_cnt", 32'(snap_cnt), 32'd8);
        repeat (200) cyc();
        chk("t5_still_idle", 32'(busy), 32'd0);

        // 5c: start and stop together
        start = 1'b1; stop = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("t5_start_stop_idle", 32'(busy), 32'd0);

        // 6: reset mid-frame
        mode_cont = 1'b0;
        run_to_beat(100);
        f = src_frame; pass_frame[f + 1] = 1'b1;
        pulse_start();
        run_to(f + 1, 600, 3000);
        chk("t6_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_s_tready", 32'(s_tready), 32'd0);
        chk("t6_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        pass_frame[f + 1] = 1'b0;
        exp_q.delete();
        repeat (3) cyc();
        reset_n = 1'b1;
        repeat (3) cyc();
        chk("t6_rel_s_tready", 32'(s_tready), 32'd1);
        chk("t6_rel_m_tvalid", 32'(m_tvalid), 32'd0);
        repeat (600) cyc();
        chk("t6_idle", 32'(busy), 32'd0);
        chk("t6_frame_cnt_end", 32'(frame_cnt), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
